disp_scan_ctrl: RTL and testbench
=================================

# disp_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display. It steps the digit index `light` presented to the combinational digit mux and latches the returned digit code `num` after a blanking interval. It decodes the code to active-low segments and drives the one-hot active-low anodes. It also applies per-digit blink and decimal-point masks for the set/alarm editing modes.

## Interface
Parameters:
- `DIV_SCAN`, 100000: clock cycles per digit slot (1 kHz/digit at 100 MHz); must be > `BLANK_CYC`.
- `BLANK_CYC`, 200: cycles at slot start with all anodes off (anti-ghosting); must be ≥ 2.
- `BLINK_DIV`, 25000000: cycles per blink phase toggle.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  scan enable; 0 blanks the display.
- `num`  in  11  digit code returned by the digit mux for the current `light`.
- `blink_mask`  in  8  bit i=1: digit i blinks.
- `dp_mask`  in  8  bit i=1: decimal point lit on digit i.
- `light`  out  3  digit index to digit mux; 0 = leftmost.
- `an`  out  8  anodes, active-low; digit i drives `an[7-i]`.
- `seg`  out  8  active-low `{dp,g,f,e,d,c,b,a}`.
- `frame_tick`  out  1  one-cycle pulse at the end of digit 7's slot.

## Operation
- Reset values: `light`=0, `an`=8'hFF, `seg`=8'hFF, `frame_tick`=0, blink phase=0 (visible), slot counter=0, blink counter=0, state BLANK.
- State machine, two states per slot, counted by slot counter `sc` (0..`DIV_SCAN`-1):
  - BLANK (`sc` < `BLANK_CYC`): `an`=8'hFF, `seg`=8'hFF; `light` holds the new digit index so `num` settles.
  - SHOW (`sc` ≥ `BLANK_CYC`): `an` has exactly one low bit for the current `light`; `seg` comes from the latched code.
  - BLANK→SHOW when `sc`=`BLANK_CYC`-1. SHOW→BLANK when `sc`=`DIV_SCAN`-1, with `light` ← `light`+1 mod 8 and `sc` ← 0.
- Capture: `num` is sampled into the code register on the edge that ends `sc`=`BLANK_CYC`-1. Later changes to `num` within the slot are ignored.
- Decode (seg bits a..g, active-low): codes 0–9 use the standard digits. Code 11 is a dash (only g lit). Code 12 and all other values are blank.
  - 0→7'b1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000 (listed g..a).
- dp: `seg[7]`=0 when `dp_mask[light]`=1 and the digit is not blink-suppressed.
- Blink:
  - The blink counter runs whenever not in reset, independent of `en`. It toggles the blink phase every `BLINK_DIV` cycles.
  - Phase 1 with `blink_mask[light]`=1 forces `seg`=8'hFF for that slot. The anode still follows the state machine.
  - Mask and phase are evaluated every cycle, not latched.
- `frame_tick`=1 for exactly the cycle with `light`=7 and `sc`=`DIV_SCAN`-1.
- `en`=0 (sampled on any cycle):
  - Next cycle: `an`=8'hFF, `seg`=8'hFF, `light`=0, `sc`=0, state BLANK, `frame_tick`=0.
  - Everything holds while `en`=0.
  - When `en` rises, a full BLANK slot for digit 0 starts on the following cycle.
- Counter widths are `$clog2` of the respective parameter. `light` wraps 7→0 with no gap.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `light` changes on the first cycle of a slot (`sc`=0). `num` must be valid within `BLANK_CYC`-1 cycles.
- Code latency: `num` sampled at `sc`=`BLANK_CYC`-1; decoded `seg` and active `an` appear together at `sc`=`BLANK_CYC`.
- Frame period is 8×`DIV_SCAN` cycles. Duty per digit is (`DIV_SCAN`-`BLANK_CYC`)/`DIV_SCAN`.
- A blink phase change mid-SHOW takes effect on `seg` the next cycle.
- Async `rst` mid-slot forces reset values immediately. Scanning resumes from digit 0 `sc`=0 on the first edge after release.

## Test plan
Bench parameters: `DIV_SCAN`=8, `BLANK_CYC`=2, `BLINK_DIV`=20.
- Reset then `en`=1, `num` follows `light` (code = index): `light` steps 0..7 every 8 cycles. `an` = 8'hFF for 2 cycles, then 8'b0111_1111 for digit 0, and so on. `frame_tick` pulses once per 64 cycles.
- `num`=11 on digit 2, `num`=12 on digit 5, `num`=3 held then changed to 8 at `sc`=4 of digit 3:
  - digit 2 `seg`=8'b1011_1111;
  - digit 5 `seg`=8'hFF;
  - digit 3 keeps the pattern for 3 (`seg`=8'b1011_0000) for the whole slot.
- `dp_mask`=8'h01, `num`=8 everywhere: digit 0 `seg`=8'h00; other digits `seg`=8'h80.
- `blink_mask`=8'h03: digits 0–1 `seg`=8'hFF during cycles 20–39, 60–79 after reset and normal elsewhere. Digits 2–7 are never blanked.
- `en` dropped at `light`=4, `sc`=5:
  - next cycle `an`=`seg`=8'hFF, `light`=0, with no `frame_tick`;
  - re-enable gives 2 blank cycles, then digit 0 active.
- Assert `rst` mid-SHOW of digit 6: `an`, `seg` = 8'hFF and `light`=0 before the next clock edge. After release, scanning restarts at digit 0.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
//   Time-multiplexed scan controller for an 8-digit seven-segment display.
//   Steps the digit index presented to an external digit mux. After a
//   blanking interval it latches the returned code, decodes it to active-low
//   segments and drives one active-low anode. Per-digit blink and
//   decimal-point masks are applied on top of the decoded pattern.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-high
//   en          scan enable; 0 blanks the display and parks on digit 0
//   num[10:0]   digit code from the digit mux for the current light
//   blink_mask  bit i=1: digit i blinks
//   dp_mask     bit i=1: decimal point lit on digit i
//   light[2:0]  digit index to the digit mux, 0 = leftmost
//   an[7:0]     anodes, active-low, digit i on an[7-i]
//   seg[7:0]    segments, active-low {dp,g,f,e,d,c,b,a}
//   frame_tick  one-cycle pulse in the last cycle of digit 7's slot
//
// state | meaning
// ------+-----------------------------------------------------------
// BLANK | sc < BLANK_CYC: anodes off, light settling the digit mux
// SHOW  | sc >= BLANK_CYC: one anode on, segments from latched code
module disp_scan_ctrl #(
  parameter int DIV_SCAN  = 100000,
  parameter int BLANK_CYC = 200,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [10:0] num,
  input  logic [7:0]  blink_mask,
  input  logic [7:0]  dp_mask,
  output logic [2:0]  light,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int SC_W = $clog2(DIV_SCAN);
  localparam int BC_W = $clog2(BLINK_DIV);

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(DIV_SCAN - 1);
  localparam logic [SC_W-1:0] SC_CAP  = SC_W'(BLANK_CYC - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_DIV - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [SC_W-1:0] sc, sc_n;
  logic [2:0]      light_n;
  logic [0:0]      state, state_n;
  logic            idle, idle_n;
  logic [10:0]     code, code_n;
  logic [BC_W-1:0] bc, bc_n;
  logic            ph, ph_n;
  logic [7:0]      an_n, seg_n;
  logic            ft_n;
  logic            cap;
  logic            blanked;

  // Codes 0-9 are digits, 11 is a dash, everything else is blank.
  function automatic logic [6:0] seg_decode(input logic [10:0] c);
    logic [6:0] s;
    case (c)
      11'd0:   s = 7'b1000000;
      11'd1:   s = 7'b1111001;
      11'd2:   s = 7'b0100100;
      11'd3:   s = 7'b0110000;
      11'd4:   s = 7'b0011001;
      11'd5:   s = 7'b0010010;
      11'd6:   s = 7'b0000010;
      11'd7:   s = 7'b1111000;
      11'd8:   s = 7'b0000000;
      11'd9:   s = 7'b0010000;
      11'd11:  s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Outputs are computed from the next-state values and registered, so
  // an/seg/frame_tick always line up with the sc/light/state registers.
  always_comb begin
    sc_n    = sc;
    light_n = light;
    state_n = state;
    idle_n  = idle;
    cap     = 1'b0;

    if (!en) begin
      idle_n  = 1'b1;
      sc_n    = '0;
      light_n = 3'd0;
      state_n = ST_BLANK;
    end else if (idle) begin
      // First enabled edge after reset or en=0 opens a fresh digit-0 slot.
      idle_n  = 1'b0;
      sc_n    = '0;
      light_n = 3'd0;
      state_n = ST_BLANK;
    end else if (sc == SC_LAST) begin
      sc_n    = '0;
      light_n = light + 3'd1;
      state_n = ST_BLANK;
    end else begin
      sc_n = sc + 1'b1;
      if (state == ST_BLANK && sc == SC_CAP) begin
        state_n = ST_SHOW;
        cap     = 1'b1;
      end
    end

    code_n = cap ? num : code;

    if (bc == BC_LAST) begin
      bc_n = '0;
      ph_n = ~ph;
    end else begin
      bc_n = bc + 1'b1;
      ph_n = ph;
    end

    an_n    = 8'hFF;
    seg_n   = 8'hFF;
    blanked = ph_n & blink_mask[light_n];
    if (state_n == ST_SHOW) begin
      an_n = ~(8'h80 >> light_n);
      if (!blanked)
        seg_n = {~dp_mask[light_n], seg_decode(code_n)};
    end

    ft_n = (state_n == ST_SHOW) && (light_n == 3'd7) && (sc_n == SC_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc         <= '0;
      light      <= 3'd0;
      state      <= ST_BLANK;
      idle       <= 1'b1;
      code       <= '0;
      bc         <= '0;
      ph         <= 1'b0;
      an         <= 8'hFF;
      seg        <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      sc         <= sc_n;
      light      <= light_n;
      state      <= state_n;
      idle       <= idle_n;
      code       <= code_n;
      bc         <= bc_n;
      ph         <= ph_n;
      an         <= an_n;
      seg        <= seg_n;
      frame_tick <= ft_n;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
module tb_disp_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [10:0] num;
  logic [7:0]  blink_mask;
  logic [7:0]  dp_mask;
  logic [2:0]  light;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  logic [10:0] mux_tab [8];

  int n_checks = 0;
  int n_fail   = 0;
  int n_edge   = 0;
  int ft_cnt   = 0;

  typedef struct {
    int         edge_n;
    logic [2:0] e_light;
    logic [7:0] e_an;
    logic [7:0] e_seg;
    logic       e_ft;
  } vec_t;

  vec_t tab [$];

  disp_scan_ctrl #(
    .DIV_SCAN (8),
    .BLANK_CYC(2),
    .BLINK_DIV(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .num       (num),
    .blink_mask(blink_mask),
    .dp_mask   (dp_mask),
    .light     (light),
    .an        (an),
    .seg       (seg),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench acts as the digit mux.
  always_comb num = mux_tab[light];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n_edge);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n_edge++;
    if (frame_tick) ft_cnt++;
  endtask

  task automatic step_to(input int target);
    while (n_edge < target) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    n_edge = 0;
    ft_cnt = 0;
  endtask

  task automatic add(input int e, input logic [2:0] l, input logic [7:0] a,
                     input logic [7:0] s, input logic f);
    vec_t v;
    v.edge_n  = e;
    v.e_light = l;
    v.e_an    = a;
    v.e_seg   = s;
    v.e_ft    = f;
    tab.push_back(v);
  endtask

  task automatic run_tab(input string tag);
    foreach (tab[i]) begin
      step_to(tab[i].edge_n);
      chk({tag, "_light"}, {5'd0, light}, {5'd0, tab[i].e_light});
      chk({tag, "_an"}, an, tab[i].e_an);
      chk({tag, "_seg"}, seg, tab[i].e_seg);
      chk({tag, "_ft"}, {7'd0, frame_tick}, {7'd0, tab[i].e_ft});
    end
    tab.delete();
  endtask

  task automatic mux_index();
    for (int i = 0; i < 8; i++) mux_tab[i] = 11'(i);
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b1;
    blink_mask = 8'h00;
    dp_mask    = 8'h00;
    mux_index();

    #1;
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_light", {5'd0, light}, 8'd0);
    chk("rst_ft", {7'd0, frame_tick}, 8'd0);

    // Basic scan, code = digit index.
    do_reset();
    add(1,   3'd0, 8'hFF, 8'hFF, 1'b0);
    add(2,   3'd0, 8'hFF, 8'hFF, 1'b0);
    add(3,   3'd0, 8'h7F, 8'hC0, 1'b0);
    add(8,   3'd0, 8'h7F, 8'hC0, 1'b0);
    add(9,   3'd1, 8'hFF, 8'hFF, 1'b0);
    add(11,  3'd1, 8'hBF, 8'hF9, 1'b0);
    add(19,  3'd2, 8'hDF, 8'hA4, 1'b0);
    add(27,  3'd3, 8'hEF, 8'hB0, 1'b0);
    add(35,  3'd4, 8'hF7, 8'h99, 1'b0);
    add(43,  3'd5, 8'hFB, 8'h92, 1'b0);
    add(51,  3'd6, 8'hFD, 8'h82, 1'b0);
    add(59,  3'd7, 8'hFE, 8'hF8, 1'b0);
    add(63,  3'd7, 8'hFE, 8'hF8, 1'b0);
    add(64,  3'd7, 8'hFE, 8'hF8, 1'b1);
    add(65,  3'd0, 8'hFF, 8'hFF, 1'b0);
    add(128, 3'd7, 8'hFE, 8'hF8, 1'b1);
    run_tab("scan");
    chk("ft_count", 8'(ft_cnt), 8'd2);

    // Dash, blank code, and code held after capture despite num change.
    mux_index();
    mux_tab[2] = 11'd11;
    mux_tab[5] = 11'd12;
    do_reset();
    step_to(19);
    chk("dash_seg", seg, 8'hBF);
    chk("dash_an", an, 8'hDF);
    step_to(29);
    chk("hold_seg_sc4", seg, 8'hB0);
    mux_tab[3] = 11'd8;
    step_to(30);
    chk("hold_seg_sc5", seg, 8'hB0);
    step_to(32);
    chk("hold_seg_sc7", seg, 8'hB0);
    step_to(33);
    chk("hold_next_an", an, 8'hFF);
    step_to(43);
    chk("blank_code_seg", seg, 8'hFF);
    chk("blank_code_an", an, 8'hFB);

    // Decimal point on digit 0 only.
    for (int i = 0; i < 8; i++) mux_tab[i] = 11'd8;
    dp_mask = 8'h01;
    do_reset();
    add(3,  3'd0, 8'h7F, 8'h00, 1'b0);
    add(11, 3'd1, 8'hBF, 8'h80, 1'b0);
    add(59, 3'd7, 8'hFE, 8'h80, 1'b0);
    run_tab("dp");

    // Blink on digits 0-1; phase 1 during edges 20-39 and 60-79.
    dp_mask    = 8'h00;
    blink_mask = 8'h03;
    do_reset();
    add(3,  3'd0, 8'h7F, 8'h80, 1'b0);
    add(8,  3'd0, 8'h7F, 8'h80, 1'b0);
    add(16, 3'd1, 8'hBF, 8'h80, 1'b0);
    add(19, 3'd2, 8'hDF, 8'h80, 1'b0);
    add(20, 3'd2, 8'hDF, 8'h80, 1'b0);
    add(27, 3'd3, 8'hEF, 8'h80, 1'b0);
    add(35, 3'd4, 8'hF7, 8'h80, 1'b0);
    add(40, 3'd4, 8'hF7, 8'h80, 1'b0);
    add(64, 3'd7, 8'hFE, 8'h80, 1'b1);
    add(67, 3'd0, 8'h7F, 8'hFF, 1'b0);
    add(72, 3'd0, 8'h7F, 8'hFF, 1'b0);
    add(75, 3'd1, 8'hBF, 8'hFF, 1'b0);
    add(79, 3'd1, 8'hBF, 8'hFF, 1'b0);
    add(80, 3'd1, 8'hBF, 8'h80, 1'b0);
    run_tab("blink");

    // Enable dropped at light=4, sc=5, then restored.
    blink_mask = 8'h00;
    mux_index();
    do_reset();
    step_to(38);
    chk("en_pre_light", {5'd0, light}, 8'd4);
    chk("en_pre_an", an, 8'hF7);
    en = 1'b0;
    tick();
    chk("en_off_an", an, 8'hFF);
    chk("en_off_seg", seg, 8'hFF);
    chk("en_off_light", {5'd0, light}, 8'd0);
    chk("en_off_ft", {7'd0, frame_tick}, 8'd0);
    repeat (3) tick();
    chk("en_hold_an", an, 8'hFF);
    chk("en_hold_light", {5'd0, light}, 8'd0);
    en = 1'b1;
    tick();
    chk("en_re1_an", an, 8'hFF);
    tick();
    chk("en_re2_an", an, 8'hFF);
    tick();
    chk("en_re3_an", an, 8'h7F);
    chk("en_re3_seg", seg, 8'hC0);
    chk("en_re3_light", {5'd0, light}, 8'd0);

    // Async reset mid-SHOW of digit 6.
    do_reset();
    step_to(53);
    chk("mid_an", an, 8'hFD);
    chk("mid_seg", seg, 8'h82);
    #2;
    rst = 1'b1;
    #1;
    chk("async_an", an, 8'hFF);
    chk("async_seg", seg, 8'hFF);
    chk("async_light", {5'd0, light}, 8'd0);
    chk("async_ft", {7'd0, frame_tick}, 8'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    n_edge = 0;
    tick();
    chk("rel1_light", {5'd0, light}, 8'd0);
    chk("rel1_an", an, 8'hFF);
    tick();
    tick();
    chk("rel3_an", an, 8'h7F);
    chk("rel3_seg", seg, 8'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
